// File: rtl/pt_pkg.sv
// Shared definitions for the Pan-Tompkins stage sequencer and the filter
// stages it drives.
//   pt_state_t        : sequencer state encoding (IDLE=0, WARMUP=1, RUN=2, DRAIN=3)
//   PT_NB_STAGES      : number of filter stages in the chain (LPF, HPF, deriv, square, MWI)
//   PT_WARMUP_SAMPLES : completed samples discarded while the chain settles
//   PT_DATA_WIDTH     : sample width (signed)
//   PT_CNT_WIDTH      : width of warm-up and statistics counters
package pt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } pt_state_t;

    localparam int PT_NB_STAGES      = 5;
    localparam int PT_WARMUP_SAMPLES = 54;
    localparam int PT_DATA_WIDTH     = 16;
    localparam int PT_CNT_WIDTH      = 16;

endpackage

// File: rtl/pt_enable_wave.sv
// Enable-wave shift register. Each launch injects a one into bit 0; the one
// walks up one stage per clock, so bit k is the enable for filter stage k.
// Several waves may be in flight at once.
// Ports:
//   clk      in   clock
//   rstn     in   asynchronous reset, active low
//   launch   in   start a new wave at stage 0 on this edge
//   stage_en out  NB_STAGES  per-stage enables (the register itself)
//   empty    out  no enable will be high after the coming edge
// NB_STAGES must be at least 2.
module pt_enable_wave
    import pt_pkg::*;
#(
    parameter int NB_STAGES = PT_NB_STAGES
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 launch,
    output logic [NB_STAGES-1:0] stage_en,
    output logic                 empty
);

    logic [NB_STAGES-1:0] wave;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wave <= '0;
        end else begin
            wave <= {wave[NB_STAGES-2:0], launch};
        end
    end

    assign stage_en = wave;

    // Looks one edge ahead: the top bit falls off on the next shift, so only
    // the lower bits and a new launch can keep the register occupied. This
    // lets the sequencer leave DRAIN in the same cycle the last enable fires.
    assign empty = ~launch & ~(|wave[NB_STAGES-2:0]);

endmodule

// File: rtl/pt_stage_sequencer.sv
// Sample-rate sequencer for the Pan-Tompkins filter chain.
// Accepts ADC samples over valid/ready, registers each accepted sample as the
// chain input and launches one enable wave per sample across the stages, one
// stage per clock. Results are suppressed until WARMUP_SAMPLES samples have
// passed the last stage; after that every last-stage enable is flagged valid.
//
// Handshake: a sample is accepted on any edge where s_valid & s_ready; s_ready
// depends only on the state register, never on s_valid, and at most one sample
// is taken per clock.
//
// Ports:
//   clk        in   clock
//   rstn       in   asynchronous reset, active low
//   start      in   pulse: begin a run (honoured only in IDLE, loses to stop)
//   stop       in   pulse: end the run, let in-flight waves drain
//   s_valid    in   sample valid
//   s_data     in   DATA_WIDTH signed sample
//   s_ready    out  sequencer can accept a sample (WARMUP or RUN)
//   stage_xin  out  DATA_WIDTH registered sample for stage 0, held until next accept
//   stage_en   out  NB_STAGES per-stage enables
//   out_valid  out  last-stage result is settled and valid this cycle
//   settled    out  warm-up complete (level, held through DRAIN)
//   busy       out  state != IDLE
//   dropped    out  sticky: a sample was offered while s_ready was low
//   sample_cnt out  CNT_WIDTH accepted samples since start   (PT_SEQ_STATS_EN only)
//   drop_cnt   out  CNT_WIDTH dropped samples since start    (PT_SEQ_STATS_EN only)
//   state_dbg  out  2-bit state encoding for observation
//
// Build option: define PT_SEQ_STATS_EN to add the sample_cnt / drop_cnt
// statistics counters and ports.
module pt_stage_sequencer
    import pt_pkg::*;
#(
    parameter int DATA_WIDTH     = PT_DATA_WIDTH,
    parameter int NB_STAGES      = PT_NB_STAGES,
    parameter int WARMUP_SAMPLES = PT_WARMUP_SAMPLES,
    parameter int CNT_WIDTH      = PT_CNT_WIDTH
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         s_valid,
    input  logic signed [DATA_WIDTH-1:0] s_data,
    output logic                         s_ready,
    output logic signed [DATA_WIDTH-1:0] stage_xin,
    output logic [NB_STAGES-1:0]         stage_en,
    output logic                         out_valid,
    output logic                         settled,
    output logic                         busy,
    output logic                         dropped,
`ifdef PT_SEQ_STATS_EN
    output logic [CNT_WIDTH-1:0]         sample_cnt,
    output logic [CNT_WIDTH-1:0]         drop_cnt,
`endif
    output logic [1:0]                   state_dbg
);

    localparam logic [CNT_WIDTH-1:0] WARMUP_CNT = CNT_WIDTH'(WARMUP_SAMPLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    pt_state_t            state;
    logic [CNT_WIDTH-1:0] done_cnt;
    logic                 wave_empty;
    logic                 accept;
    logic                 drop;
    logic                 start_acc;
    logic                 warm_done;

    assign s_ready   = (state == ST_WARMUP) || (state == ST_RUN);
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

    assign accept    = s_valid & s_ready;
    assign drop      = s_valid & ~s_ready;
    // stop has priority over start in the same cycle.
    assign start_acc = start & ~stop & (state == ST_IDLE);

    assign warm_done = (done_cnt == WARMUP_CNT);
    // done_cnt is the count before this enable, so the first qualified result
    // is sample WARMUP_SAMPLES+1.
    assign out_valid = stage_en[NB_STAGES-1] & warm_done;

    pt_enable_wave #(
        .NB_STAGES (NB_STAGES)
    ) u_wave (
        .clk      (clk),
        .rstn     (rstn),
        .launch   (accept),
        .stage_en (stage_en),
        .empty    (wave_empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            settled   <= 1'b0;
            dropped   <= 1'b0;
            done_cnt  <= '0;
            stage_xin <= '0;
        end else begin
            if (accept) begin
                stage_xin <= s_data;
            end

            // A drop in the same cycle as the clearing start still registers.
            dropped <= (start_acc ? 1'b0 : dropped) | drop;

            // Saturates at the warm-up target; it only has to tell "settled".
            if (start_acc) begin
                done_cnt <= '0;
            end else if (stage_en[NB_STAGES-1] && !warm_done) begin
                done_cnt <= done_cnt + CNT_ONE;
            end

            case (state)
                ST_IDLE: begin
                    if (start_acc) begin
                        state   <= ST_WARMUP;
                        settled <= 1'b0;
                    end
                end
                ST_WARMUP: begin
                    if (stop) begin
                        state <= ST_DRAIN;
                    end else if (warm_done) begin
                        state   <= ST_RUN;
                        settled <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // No launches here, so at most NB_STAGES cycles in DRAIN.
                    if (wave_empty) begin
                        state   <= ST_IDLE;
                        settled <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PT_SEQ_STATS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sample_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            // No sample can be accepted in IDLE, so start simply clears.
            if (start_acc) begin
                sample_cnt <= '0;
            end else if (accept && (sample_cnt != '1)) begin
                sample_cnt <= sample_cnt + CNT_ONE;
            end

            if (start_acc) begin
                drop_cnt <= drop ? CNT_ONE : '0;
            end else if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_ONE;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pt_stage_sequencer.sv
// Bench for pt_stage_sequencer. A reference model tracks the edge at which
// every sample was accepted and derives the expected enables, validity and
// status outputs from those timestamps; a checker compares every cycle, and
// directed sequences check the headline scenarios with fixed numbers.
// Define PT_SEQ_STATS_EN for both bench and RTL to cover the statistics ports.
module tb_pt_stage_sequencer;

    localparam int DW   = 16;
    localparam int NB   = 5;
    localparam int W    = 54;
    localparam int CW   = 16;
    localparam int AMAX = 8192;

    // ---------------- clock / reset / DUT ----------------
    logic          clk     = 1'b0;
    logic          rstn    = 1'b1;
    logic          start   = 1'b0;
    logic          stop    = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data  = '0;
    logic          s_ready;
    logic [DW-1:0] stage_xin;
    logic [NB-1:0] stage_en;
    logic          out_valid;
    logic          settled;
    logic          busy;
    logic          dropped;
    logic [1:0]    state_dbg;
`ifdef PT_SEQ_STATS_EN
    logic [CW-1:0] sample_cnt;
    logic [CW-1:0] drop_cnt;
`endif

    always #5 clk = ~clk;

    pt_stage_sequencer #(
        .DATA_WIDTH     (DW),
        .NB_STAGES      (NB),
        .WARMUP_SAMPLES (W),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .stop       (stop),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .stage_xin  (stage_xin),
        .stage_en   (stage_en),
        .out_valid  (out_valid),
        .settled    (settled),
        .busy       (busy),
        .dropped    (dropped),
`ifdef PT_SEQ_STATS_EN
        .sample_cnt (sample_cnt),
        .drop_cnt   (drop_cnt),
`endif
        .state_dbg  (state_dbg)
    );

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // e counts clock edges since reset; acc_at[i] marks an accept at edge i.
    // Stage k is enabled in the cycle following edge i+k.
    int            e         = 0;
    bit            acc_at[AMAX];
    int            mode      = 0;   // 0 idle, 1 taking samples, 2 draining
    bit            m_settled = 1'b0;
    bit            m_dropped = 1'b0;
    int            m_done    = 0;   // last-stage completions since start, capped at W
    logic [DW-1:0] m_xin     = '0;
    int            m_scnt    = 0;
    int            m_dcnt    = 0;
    logic [DW-1:0] exp_q[$];

    function automatic logic [NB-1:0] exp_en_now();
        logic [NB-1:0] r;
        r = '0;
        for (int k = 0; k < NB; k++) begin
            int idx;
            idx = e - 1 - k;
            if (idx >= 0 && idx < AMAX) r[k] = acc_at[idx];
        end
        return r;
    endfunction

    initial begin
        logic [NB-1:0] en;
        bit acc, drp, st;
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                e = 0;
                for (int i = 0; i < AMAX; i++) acc_at[i] = 1'b0;
                mode = 0; m_settled = 0; m_dropped = 0; m_done = 0;
                m_xin = '0; m_scnt = 0; m_dcnt = 0;
                exp_q.delete();
            end else begin
                en  = exp_en_now();
                acc = s_valid && (mode == 1);
                drp = s_valid && (mode != 1);
                st  = start && !stop && (mode == 0);
                if (acc) begin
                    if (e < AMAX) acc_at[e] = 1'b1;
                    m_xin = s_data;
                    exp_q.push_back(s_data);
                end
                m_dropped = (st ? 1'b0 : m_dropped) | drp;
                if (st) m_scnt = 0;
                else if (acc && m_scnt < 65535) m_scnt++;
                if (st) m_dcnt = drp ? 1 : 0;
                else if (drp && m_dcnt < 65535) m_dcnt++;
                // state rules use the completion count from before this edge
                case (mode)
                    0: if (st) begin mode = 1; m_settled = 0; end
                    1: begin
                        if (stop) mode = 2;
                        else if (!m_settled && m_done == W) m_settled = 1;
                    end
                    default: if (en[NB-2:0] == '0) begin mode = 0; m_settled = 0; end
                endcase
                if (st) m_done = 0;
                else if (en[NB-1] && m_done < W) m_done++;
                e++;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        logic [NB-1:0] en;
        logic [1:0]    st_exp;
        forever begin
            @(negedge clk);
            en = exp_en_now();
            st_exp = (mode == 0) ? 2'd0 : (mode == 1) ? (m_settled ? 2'd2 : 2'd1) : 2'd3;
            check("stage_en",  stage_en,  en);
            check("out_valid", out_valid, en[NB-1] && (m_done == W));
            check("s_ready",   s_ready,   mode == 1);
            check("busy",      busy,      mode != 0);
            check("settled",   settled,   m_settled);
            check("dropped",   dropped,   m_dropped);
            check("stage_xin", stage_xin, m_xin);
            check("state",     state_dbg, st_exp);
`ifdef PT_SEQ_STATS_EN
            check("sample_cnt", sample_cnt, m_scnt);
            check("drop_cnt",   drop_cnt,   m_dcnt);
`endif
            // stage 0 fires exactly once per accepted sample, with its data on xin
            if (en[0]) begin
                check("sb_depth", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("xin_sb", stage_xin, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver ----------------
    int n_last = 0;
    int n_ov   = 0;
    bit s53 = 0, s55 = 0, ov54 = 0, ov55 = 0;

    // Drive inputs for one clock, then observe shortly after the falling edge.
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic st, input logic sp);
        s_valid = v;
        s_data  = d;
        start   = st;
        stop    = sp;
        @(negedge clk);
        #1;
        if (stage_en[NB-1]) begin
            n_last++;
            if (n_last == 53) s53  = settled;
            if (n_last == 54) ov54 = out_valid;
            if (n_last == 55) begin s55 = settled; ov55 = out_valid; end
        end
        if (out_valid) n_ov++;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] d;
        int drain_cycles;

        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_stage_en", stage_en, 0);
        check("rst_busy", busy, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_dropped", dropped, 0);
        rstn = 1'b1;

        // 1: warm-up over 60 samples spaced 4 clocks
        cyc(0, '0, 1, 0);
        n_last = 0; n_ov = 0;
        for (int i = 0; i < 60; i++) begin
            cyc(1, 16'($urandom), 0, 0);
            repeat (3) cyc(0, '0, 0, 0);
        end
        repeat (8) cyc(0, '0, 0, 0);
        check("t1_last_pulses", n_last, 60);
        check("t1_out_valids", n_ov, 6);
        check("t1_settled_53", s53, 0);
        check("t1_settled_55", s55, 1);
        check("t1_ov_54", ov54, 0);
        check("t1_ov_55", ov55, 1);

        // 2: single wave timing and data
        d = 16'($urandom);
        cyc(1, d, 0, 0);
        check("t2_en_0", stage_en, 5'b00001);
        check("t2_xin", stage_xin, d);
        for (int k = 1; k < NB; k++) begin
            cyc(0, '0, 0, 0);
            check("t2_en_k", stage_en, 5'b00001 << k);
        end
        cyc(0, '0, 0, 0);
        check("t2_en_done", stage_en, 0);

        // 3: back-to-back accepts for 20 clocks
        n_ov = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc(1, 16'($urandom), 0, 0);
            check("t3_ready", s_ready, 1);
            if (i >= NB) check("t3_all_en", stage_en, 5'b11111);
        end
        repeat (6) cyc(0, '0, 0, 0);
        check("t3_out_valids", n_ov, 20);

        // 4: stop with three waves in flight
        cyc(1, 16'($urandom), 0, 0);
        cyc(0, '0, 0, 0);
        cyc(1, 16'($urandom), 0, 0);
        cyc(0, '0, 0, 0);
        cyc(1, 16'($urandom), 0, 0);
        cyc(0, '0, 0, 1);
        check("t4_ready_low", s_ready, 0);
        check("t4_busy_drain", busy, 1);
        drain_cycles = 0;
        while (busy && drain_cycles < 5) begin
            cyc(0, '0, 0, 0);
            drain_cycles++;
        end
        check("t4_idle_in_5", busy, 0);

        // 5: drop in IDLE, start&stop together, then a real start
        cyc(1, 16'sh1234, 0, 0);
        check("t5_no_en", stage_en, 0);
        check("t5_dropped", dropped, 1);
        cyc(0, '0, 0, 0);
        check("t5_no_en2", stage_en, 0);
        cyc(0, '0, 1, 1);
        check("t5_startstop_idle", busy, 0);
        check("t5_dropped_kept", dropped, 1);
        cyc(0, '0, 1, 0);
        check("t5_dropped_clr", dropped, 0);
        check("t5_busy", busy, 1);

        // 6: asynchronous reset mid-run with waves in flight
        for (int i = 0; i < 64; i++) cyc(1, 16'($urandom), 0, 0);
        check("t6_in_run", settled, 1);
        check("t6_waves", stage_en, 5'b11111);
        s_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("t6_rst_en", stage_en, 0);
        check("t6_rst_ov", out_valid, 0);
        check("t6_rst_settled", settled, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ready", s_ready, 0);
        check("t6_rst_xin", stage_xin, 0);
        check("t6_rst_state", state_dbg, 0);
        @(negedge clk);
        @(negedge clk);
        #1 rstn = 1'b1;
        cyc(0, '0, 0, 0);
        cyc(0, '0, 0, 0);
        check("t6_idle", busy, 0);
        cyc(1, 16'($urandom), 0, 0);
        check("t6_needs_start", stage_en, 0);
        check("t6_drop_after", dropped, 1);

        // random traffic with occasional start / stop, checked by the model
        cyc(0, '0, 1, 0);
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 3) != 0, 16'($urandom),
                $urandom_range(0, 15) == 0, $urandom_range(0, 119) == 0);
        end
        repeat (8) cyc(0, '0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
